// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 arrow-key front end: scan codes, key bit
// positions and the receive FSM encoding.
package ps2_pkg;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_OVR0  = 8'h00;
    localparam logic [7:0] SC_OVR1  = 8'hFF;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;
endpackage

// File: rtl/ps2_keys_if.sv
// PS/2 line inputs plus decoded key/scan outputs of ps2_keys.
interface ps2_keys_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keys;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       frame_err;

    modport master (output ps2_clk, ps2_data,
                    input  keys, scan_valid, scan_code, frame_err);
    modport slave  (input  ps2_clk, ps2_data,
                    output keys, scan_valid, scan_code, frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: synchronizes and deglitches the keyboard clock, then
// frames start/8 data/odd parity/stop bits on its falling edges.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       scan_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall_q, fall_d;

    rx_state_e     state_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tcnt_q;
    logic          valid_q, err_q;
    logic [7:0]    code_q;

    // The level only flips once FILTER_LEN samples in a row disagree with it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
            else                               fcnt_d = fcnt_q + 1'b1;
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fall_q   <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fall_q   <= fall_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (fall_q) begin
                tcnt_q <= '0;
                case (state_q)
                    ST_IDLE: if (!dat_s2_q) begin
                        state_q  <= ST_DATA;
                        bitcnt_q <= '0;
                    end
                    ST_DATA: begin
                        shift_q  <= {dat_s2_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        if (bitcnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s2_q;
                        state_q <= ST_STOP;
                    end
                    default: begin
                        if (dat_s2_q && (^{shift_q, par_q})) begin
                            valid_q <= 1'b1;
                            code_q  <= shift_q;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (state_q != ST_IDLE) begin
                // A keyboard that stops clocking mid-frame must not wedge the FSM.
                if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b1;
                    tcnt_q  <= '0;
                end else begin
                    tcnt_q <= tcnt_q + 1'b1;
                end
            end else begin
                tcnt_q <= '0;
            end
        end
    end

    assign scan_valid_o = valid_q;
    assign scan_code_o  = code_q;
    assign frame_err_o  = err_q;
endmodule

// File: rtl/ps2_keys.sv
// Arrow-key state from a PS/2 keyboard: receiver plus E0/F0 prefix decode
// driving a level-held 4-bit keys bus.
module ps2_keys
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic       clk,
    input logic       rst_n,
    ps2_keys_if.slave bus
);
    logic       scan_valid, frame_err;
    logic [7:0] scan_code;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic [3:0] keys_q, keys_d;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk_i   (bus.ps2_clk),
        .ps2_data_i  (bus.ps2_data),
        .scan_valid_o(scan_valid),
        .scan_code_o (scan_code),
        .frame_err_o (frame_err)
    );

    always_comb begin
        keys_d = keys_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (scan_valid) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            case (scan_code)
                SC_EXT: begin ext_d = 1'b1; brk_d = brk_q; end
                SC_BRK: begin ext_d = ext_q; brk_d = 1'b1; end
                SC_OVR0, SC_OVR1: keys_d = '0;
                default: if (ext_q) begin
                    case (scan_code)
                        SC_UP:    keys_d[KEY_UP]    = ~brk_q;
                        SC_DOWN:  keys_d[KEY_DOWN]  = ~brk_q;
                        SC_LEFT:  keys_d[KEY_LEFT]  = ~brk_q;
                        SC_RIGHT: keys_d[KEY_RIGHT] = ~brk_q;
                        default:  ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            keys_q <= keys_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
        end
    end

    assign bus.keys       = keys_q;
    assign bus.scan_valid = scan_valid;
    assign bus.scan_code  = scan_code;
    assign bus.frame_err  = frame_err;
endmodule

// File: tb/tb_ps2_keys.sv
// Scoreboard bench for ps2_keys: frames are bit-banged on the PS/2 lines and
// each expected scan/error pulse is queued and matched as the DUT emits it.
module tb_ps2_keys;
    localparam int FLT  = 8;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic [3:0] keys;
    } evt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, bad = 0;
    int   nvalid = 0, nerr = 0;
    evt_t q[$];

    ps2_keys_if bus ();

    ps2_keys #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = bits[i];
            tick(HALF);
            bus.ps2_clk = 1'b0;
            tick(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic [3:0] exp_keys);
        evt_t e;
        logic [10:0] fr;
        e.is_err = bad_par;
        e.code   = b;
        e.keys   = exp_keys;
        q.push_back(e);
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        send_bits(fr, 11);
        tick(30);
    endtask

    // Pulse monitor: pops the oldest expectation, then checks keys one cycle later.
    always begin
        evt_t e;
        @(negedge clk);
        if (rst_n && (bus.scan_valid || bus.frame_err)) begin
            if (bus.scan_valid) nvalid++;
            if (bus.frame_err)  nerr++;
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.scan_valid, bus.frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", {30'd0, bus.scan_valid, bus.frame_err},
                    e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) chk("scan_code", bus.scan_code, e.code);
                @(negedge clk);
                chk("keys_after", bus.keys, e.keys);
            end
        end
    end

    initial begin
        int v0, e0, w;
        evt_t e;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(3);
        chk("rst_keys", bus.keys, 0);
        chk("rst_valid", bus.scan_valid, 0);
        chk("rst_code", bus.scan_code, 0);
        chk("rst_err", bus.frame_err, 0);
        rst_n = 1'b1;
        tick(5);

        // Left make, then right make, then left break.
        send_byte(8'hE0, 1'b0, 4'b0000);
        send_byte(8'h6B, 1'b0, 4'b0100);
        send_byte(8'hE0, 1'b0, 4'b0100);
        send_byte(8'h74, 1'b0, 4'b1100);
        send_byte(8'hE0, 1'b0, 4'b1100);
        send_byte(8'hF0, 1'b0, 4'b1100);
        send_byte(8'h6B, 1'b0, 4'b1000);

        // Bad parity: error only, code and keys hold.
        v0 = nvalid;
        send_byte(8'h6B, 1'b1, 4'b1000);
        chk("parity_no_valid", nvalid, v0);
        chk("code_held", bus.scan_code, 8'h6B);

        // Short clock glitches in IDLE must be filtered out.
        v0 = nvalid; e0 = nerr;
        for (int i = 0; i < 3; i++) begin
            bus.ps2_clk = 1'b0;
            tick(FLT - 1);
            bus.ps2_clk = 1'b1;
            tick(20);
        end
        chk("glitch_valid", nvalid, v0);
        chk("glitch_err", nerr, e0);

        // Partial frame then silence: timeout error.
        e.is_err = 1'b1; e.code = 8'h00; e.keys = 4'b1000;
        q.push_back(e);
        e0 = nerr;
        send_bits(11'b000_1010_1010, 4);
        tick(TO + 200);
        chk("timeout_err", nerr, e0 + 1);
        send_byte(8'hE0, 1'b0, 4'b1000);
        send_byte(8'h75, 1'b0, 4'b1001);

        // Typematic repeat and non-extended byte change nothing.
        send_byte(8'hE0, 1'b0, 4'b1001);
        send_byte(8'h75, 1'b0, 4'b1001);
        send_byte(8'h1C, 1'b0, 4'b1001);

        send_byte(8'hE0, 1'b0, 4'b1001);
        send_byte(8'h72, 1'b0, 4'b1011);
        send_byte(8'hE0, 1'b0, 4'b1011);
        send_byte(8'h6B, 1'b0, 4'b1111);
        send_byte(8'hFF, 1'b0, 4'b0000);

        // Reset in the middle of a frame.
        send_bits(11'b000_1110_0000, 5);
        rst_n = 1'b0;
        tick(3);
        chk("mid_rst_keys", bus.keys, 0);
        chk("mid_rst_valid", bus.scan_valid, 0);
        chk("mid_rst_code", bus.scan_code, 0);
        chk("mid_rst_err", bus.frame_err, 0);
        rst_n = 1'b1;
        tick(5);
        send_byte(8'hE0, 1'b0, 4'b0000);
        send_byte(8'h75, 1'b0, 4'b0001);

        w = 0;
        while (q.size() != 0 && w < 2000) begin
            tick(1);
            w++;
        end
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
